// File: rtl/board_mem_arbiter_if.sv
// Request/grant and board RAM bus bundle for the board memory arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface board_mem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 2
);
  logic              req_flip;
  logic              we_flip;
  logic [ADDR_W-1:0] addr_flip;
  logic [DATA_W-1:0] wdata_flip;
  logic              req_vali;
  logic [ADDR_W-1:0] addr_vali;
  logic              req_draw;
  logic [ADDR_W-1:0] addr_draw;

  logic              gnt_flip;
  logic              gnt_vali;
  logic              gnt_draw;
  logic              rvalid_flip;
  logic              rvalid_vali;
  logic              rvalid_draw;
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  req_flip, we_flip, addr_flip, wdata_flip,
    input  req_vali, addr_vali,
    input  req_draw, addr_draw,
    input  mem_rdata,
    output gnt_flip, gnt_vali, gnt_draw,
    output rvalid_flip, rvalid_vali, rvalid_draw, rdata,
    output mem_addr, mem_we, mem_wdata,
    output busy
  );

  modport master (
    output req_flip, we_flip, addr_flip, wdata_flip,
    output req_vali, addr_vali,
    output req_draw, addr_draw,
    output mem_rdata,
    input  gnt_flip, gnt_vali, gnt_draw,
    input  rvalid_flip, rvalid_vali, rvalid_draw, rdata,
    input  mem_addr, mem_we, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter for flipper (rd/wr), validator (rd) and display (rd).
// One transaction in flight; display is force-granted after STARVE_MAX waiting cycles.
//
//  state    | meaning
//  S_IDLE   | waiting for any request; winner latched on the edge leaving this state
//  S_ISSUE  | address (and write) on the RAM bus, grant pulse to the winner
//  S_RDWAIT | waiting RD_LAT cycles for RAM data; rvalid follows the last one
module board_mem_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 2,
  parameter int NUM_CELLS  = 100,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic               clock,
  input  logic               reset,
  board_mem_arbiter_if.slave bus
);
  localparam int WAIT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(RD_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
  localparam logic [ADDR_W:0]     CELL_END   = (ADDR_W + 1)'(NUM_CELLS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT} state_t;
  typedef enum logic [1:0] {ID_FLIP, ID_VALI, ID_DRAW} req_id_t;

  state_t            state;
  state_t            state_nxt;

  logic              any_req;
  logic              draw_forced;
  req_id_t           win_id;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [DATA_W-1:0] win_wdata;

  req_id_t           lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_oob;

  logic [WAIT_W-1:0]   wait_cnt;
  logic                rd_last;
  logic [STARVE_W-1:0] starve_cnt;
  logic                draw_issue;

  logic              rvalid_flip_q;
  logic              rvalid_vali_q;
  logic              rvalid_draw_q;
  logic [DATA_W-1:0] rdata_q;

  assign any_req     = bus.req_flip | bus.req_vali | bus.req_draw;
  assign draw_forced = bus.req_draw && (starve_cnt == STARVE_TOP);
  assign rd_last     = (wait_cnt == WAIT_LAST);
  assign draw_issue  = (state == S_ISSUE) && (lat_id == ID_DRAW);

  // Winner selection: flip > vali > draw unless the display has starved.
  always_comb begin
    win_id    = ID_DRAW;
    win_addr  = bus.addr_draw;
    win_we    = 1'b0;
    win_wdata = '0;
    if (!draw_forced && bus.req_flip) begin
      win_id    = ID_FLIP;
      win_addr  = bus.addr_flip;
      win_we    = bus.we_flip;
      win_wdata = bus.wdata_flip;
    end else if (!draw_forced && bus.req_vali) begin
      win_id   = ID_VALI;
      win_addr = bus.addr_vali;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = lat_we ? S_IDLE : S_RDWAIT;
      S_RDWAIT: if (rd_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_flip = 1'b0;
    bus.gnt_vali = 1'b0;
    bus.gnt_draw = 1'b0;
    bus.mem_we   = 1'b0;
    bus.busy     = 1'b1;
    case (state)
      S_IDLE: bus.busy = 1'b0;
      S_ISSUE: begin
        bus.gnt_flip = (lat_id == ID_FLIP);
        bus.gnt_vali = (lat_id == ID_VALI);
        bus.gnt_draw = draw_issue;
        // Off-board addresses are border cells: never written.
        bus.mem_we   = lat_we && !lat_oob;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lat_id        <= ID_FLIP;
      lat_addr      <= '0;
      lat_we        <= 1'b0;
      lat_wdata     <= '0;
      lat_oob       <= 1'b0;
      wait_cnt      <= '0;
      starve_cnt    <= '0;
      rdata_q       <= '0;
      rvalid_flip_q <= 1'b0;
      rvalid_vali_q <= 1'b0;
      rvalid_draw_q <= 1'b0;
    end else begin
      rvalid_flip_q <= 1'b0;
      rvalid_vali_q <= 1'b0;
      rvalid_draw_q <= 1'b0;

      if ((state == S_IDLE) && any_req) begin
        lat_id    <= win_id;
        lat_addr  <= win_addr;
        lat_we    <= win_we;
        lat_wdata <= win_wdata;
        lat_oob   <= ({1'b0, win_addr} >= CELL_END);
      end

      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_RDWAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if ((state == S_RDWAIT) && rd_last) begin
        rdata_q       <= lat_oob ? '0 : bus.mem_rdata;
        rvalid_flip_q <= (lat_id == ID_FLIP);
        rvalid_vali_q <= (lat_id == ID_VALI);
        rvalid_draw_q <= (lat_id == ID_DRAW);
      end

      if (!bus.req_draw || draw_issue) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_TOP) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign bus.mem_addr    = lat_addr;
  assign bus.mem_wdata   = lat_wdata;
  assign bus.rdata       = rdata_q;
  assign bus.rvalid_flip = rvalid_flip_q;
  assign bus.rvalid_vali = rvalid_vali_q;
  assign bus.rvalid_draw = rvalid_draw_q;
endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: directed cases plus random requesters, checked against a
// transaction-timeline model with its own shadow copy of the board RAM.
`timescale 1ns/1ps
module tb_board_mem_arbiter;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 2;
  localparam int NUM_CELLS  = 100;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;
  localparam int ID_F = 0;
  localparam int ID_V = 1;
  localparam int ID_D = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  board_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  board_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CELLS(NUM_CELLS),
    .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bif.slave)
  );

  // Board RAM with an extra bench write port used only while loading.
  logic [DATA_W-1:0] ram     [128];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic              tb_we    = 1'b0;
  logic [ADDR_W-1:0] tb_waddr = '0;
  logic [DATA_W-1:0] tb_wdata = '0;

  always @(posedge clock) begin
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else if (bif.mem_we) ram[bif.mem_addr] <= bif.mem_wdata;
    rd_pipe[0] <= ram[bif.mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bif.mem_rdata = rd_pipe[RD_LAT-1];

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;

  // Reference model: timeline of the one transaction in flight.
  int shadow [128];
  int m_free_at  = 0;
  int m_gnt_cyc  = -1;
  int m_busy_end = -1;
  int m_rv_cyc   = -1;
  int m_id       = 0;
  int m_addr     = 0;
  int m_wdata    = 0;
  int m_rv_data  = 0;
  int m_starve   = 0;
  bit m_we       = 1'b0;
  bit m_prev_gd  = 1'b0;
  bit m_in_reset = 1'b0;

  int mode_f = 0, mode_v = 0, mode_d = 0;  // 0 directed, 1 random, 2 continuous
  logic [2:0]        seen_gnt, seen_rv;
  logic [DATA_W-1:0] seen_rdata;
  bit                we_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit forced;
    int win, a;
    if (!reset) begin
      m_free_at = cyc + 1; m_gnt_cyc = -1; m_busy_end = -1; m_rv_cyc = -1;
      m_addr = 0; m_starve = 0; m_prev_gd = 1'b0; m_we = 1'b0; m_in_reset = 1'b1;
      return;
    end
    m_in_reset = 1'b0;
    forced = bif.req_draw && (m_starve == STARVE_MAX);
    if (!bif.req_draw || m_prev_gd) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    if (cyc >= m_free_at && (bif.req_flip || bif.req_vali || bif.req_draw)) begin
      if (forced)             win = ID_D;
      else if (bif.req_flip)  win = ID_F;
      else if (bif.req_vali)  win = ID_V;
      else                    win = ID_D;
      a = (win == ID_F) ? int'(bif.addr_flip) : (win == ID_V) ? int'(bif.addr_vali) : int'(bif.addr_draw);
      m_id = win; m_addr = a; m_gnt_cyc = cyc;
      m_we = (win == ID_F) && bif.we_flip;
      if (m_we) begin
        m_wdata = int'(bif.wdata_flip);
        if (a < NUM_CELLS) shadow[a] = m_wdata;
        m_busy_end = cyc;
        m_free_at  = cyc + 2;
      end else begin
        m_rv_data  = (a < NUM_CELLS) ? shadow[a] : 0;
        m_busy_end = cyc + RD_LAT;
        m_rv_cyc   = cyc + RD_LAT + 1;
        m_free_at  = cyc + RD_LAT + 2;
      end
    end
    m_prev_gd = (m_gnt_cyc == cyc) && (m_id == ID_D);
  endtask

  task automatic new_flip();
    bif.req_flip   = 1'b1;
    bif.we_flip    = 1'($urandom_range(0, 1));
    bif.addr_flip  = ADDR_W'($urandom_range(0, 105));
    bif.wdata_flip = DATA_W'($urandom_range(0, 2));
  endtask
  task automatic new_vali();
    bif.req_vali  = 1'b1;
    bif.addr_vali = ADDR_W'($urandom_range(0, 105));
  endtask
  task automatic new_draw();
    bif.req_draw  = 1'b1;
    bif.addr_draw = ADDR_W'($urandom_range(0, 105));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    model_edge();
    check("gnt_flip", 32'(bif.gnt_flip), 32'(m_gnt_cyc == cyc && m_id == ID_F));
    check("gnt_vali", 32'(bif.gnt_vali), 32'(m_gnt_cyc == cyc && m_id == ID_V));
    check("gnt_draw", 32'(bif.gnt_draw), 32'(m_gnt_cyc == cyc && m_id == ID_D));
    check("rvalid_flip", 32'(bif.rvalid_flip), 32'(m_rv_cyc == cyc && m_id == ID_F));
    check("rvalid_vali", 32'(bif.rvalid_vali), 32'(m_rv_cyc == cyc && m_id == ID_V));
    check("rvalid_draw", 32'(bif.rvalid_draw), 32'(m_rv_cyc == cyc && m_id == ID_D));
    check("busy", 32'(bif.busy), 32'(cyc <= m_busy_end));
    check("mem_we", 32'(bif.mem_we), 32'(m_gnt_cyc == cyc && m_we && m_addr < NUM_CELLS));
    check("mem_addr", 32'(bif.mem_addr), 32'(m_addr));
    if (m_gnt_cyc == cyc && m_we) check("mem_wdata", 32'(bif.mem_wdata), 32'(m_wdata));
    if (m_rv_cyc == cyc) check("rdata", 32'(bif.rdata), 32'(m_rv_data));
    if (m_in_reset) begin
      check("rst_rdata", 32'(bif.rdata), 0);
      check("rst_wdata", 32'(bif.mem_wdata), 0);
    end
    seen_gnt   = {bif.gnt_draw, bif.gnt_vali, bif.gnt_flip};
    seen_rv    = {bif.rvalid_draw, bif.rvalid_vali, bif.rvalid_flip};
    seen_rdata = bif.rdata;
    if (bif.mem_we) we_seen = 1'b1;
    tb_we = 1'b0;

    if (bif.gnt_flip) begin
      if (mode_f == 2) new_flip(); else bif.req_flip = 1'b0;
    end else if (!bif.req_flip && mode_f == 1 && $urandom_range(0, 3) == 0) new_flip();
    if (bif.gnt_vali) begin
      if (mode_v == 2) new_vali(); else bif.req_vali = 1'b0;
    end else if (!bif.req_vali && mode_v == 1 && $urandom_range(0, 3) == 0) new_vali();
    if (bif.gnt_draw) begin
      if (mode_d == 2) new_draw(); else bif.req_draw = 1'b0;
    end else if (!bif.req_draw && mode_d == 1 && $urandom_range(0, 3) == 0) new_draw();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !(cyc + 1 >= m_free_at && cyc >= m_rv_cyc); i++) tick();
  endtask

  task automatic issue(input string tag, input int id, input bit we, input int addr, input int wd);
    bit got;
    got = 1'b0;
    case (id)
      ID_F: begin
        bif.req_flip = 1'b1; bif.we_flip = we;
        bif.addr_flip = ADDR_W'(addr); bif.wdata_flip = DATA_W'(wd);
      end
      ID_V: begin bif.req_vali = 1'b1; bif.addr_vali = ADDR_W'(addr); end
      default: begin bif.req_draw = 1'b1; bif.addr_draw = ADDR_W'(addr); end
    endcase
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = seen_gnt[id];
    end
    check({tag, "_gnt"}, 32'(got), 1);
  endtask

  task automatic read_back(input string tag, input int id, input int addr, input int exp_data);
    int g;
    bit got;
    issue(tag, id, 1'b0, addr, 0);
    g = cyc;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = seen_rv[id];
    end
    check({tag, "_rv"}, 32'(got), 1);
    check({tag, "_lat"}, 32'(cyc - g), 32'(RD_LAT + 1));
    check({tag, "_data"}, 32'(seen_rdata), 32'(exp_data));
  endtask

  initial begin
    int q[$];
    int waited;
    bit got;
    bit rv_seen;

    bif.req_flip = 1'b0; bif.we_flip = 1'b0; bif.addr_flip = '0; bif.wdata_flip = '0;
    bif.req_vali = 1'b0; bif.addr_vali = '0;
    bif.req_draw = 1'b0; bif.addr_draw = '0;

    // Load the board while held in reset; every cycle also checks reset outputs.
    reset = 1'b0;
    for (int a = 0; a < 128; a++) begin
      int v;
      v = (a == 34) ? 1 : (a == 45) ? 0 : int'($urandom_range(0, 2));
      shadow[a] = v;
      tb_we = 1'b1; tb_waddr = ADDR_W'(a); tb_wdata = DATA_W'(v);
      tick();
    end
    reset = 1'b1;
    tick();

    read_back("rd34", ID_V, 34, 1);
    wait_idle();

    issue("wr45", ID_F, 1'b1, 45, 2);
    check("wr45_we", 32'(bif.mem_we), 1);
    check("wr45_addr", 32'(bif.mem_addr), 45);
    check("wr45_wdata", 32'(bif.mem_wdata), 2);
    wait_idle();
    read_back("rd45", ID_V, 45, 2);
    wait_idle();

    // All three requesters in the same cycle.
    bif.req_flip = 1'b1; bif.we_flip = 1'b0; bif.addr_flip = ADDR_W'(10);
    bif.req_vali = 1'b1; bif.addr_vali = ADDR_W'(11);
    bif.req_draw = 1'b1; bif.addr_draw = ADDR_W'(12);
    for (int i = 0; i < 30 && q.size() < 3; i++) begin
      tick();
      check("gnt_onehot", 32'($countones(seen_gnt) > 1), 0);
      for (int k = 0; k < 3; k++) if (seen_gnt[k]) q.push_back(k);
    end
    check("order_cnt", 32'(q.size()), 3);
    check("order0", (q.size() > 0) ? 32'(q[0]) : 32'hFFFF_FFFF, ID_F);
    check("order1", (q.size() > 1) ? 32'(q[1]) : 32'hFFFF_FFFF, ID_V);
    check("order2", (q.size() > 2) ? 32'(q[2]) : 32'hFFFF_FFFF, ID_D);
    wait_idle();

    // Starvation: flip and vali never let go, display must still get in.
    mode_f = 2; mode_v = 2;
    new_flip(); new_vali();
    bif.req_draw = 1'b1; bif.addr_draw = ADDR_W'(7);
    got = 1'b0; waited = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = seen_gnt[ID_D];
      if (!got) waited++;
    end
    check("starve_gnt", 32'(got), 1);
    check("starve_wait_min", 32'(waited >= STARVE_MAX), 1);
    mode_f = 0; mode_v = 0;
    for (int i = 0; i < 40 && (bif.req_flip || bif.req_vali); i++) tick();
    wait_idle();

    // Off-board address: write suppressed, read returns border value.
    we_seen = 1'b0;
    issue("wr100", ID_F, 1'b1, 100, 2);
    wait_idle();
    check("oob_we", 32'(we_seen), 0);
    read_back("rd100", ID_V, 100, 0);
    wait_idle();
    read_back("rd127", ID_D, 127, 0);
    wait_idle();

    // Reset in the middle of a read.
    issue("rstrd", ID_V, 1'b0, 20, 0);
    bif.req_draw = 1'b1; bif.addr_draw = ADDR_W'(5);
    tick();
    reset = 1'b0;
    tick();
    check("rst_busy", 32'(bif.busy), 0);
    rv_seen = (seen_rv != 3'b000);
    reset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = seen_gnt[ID_D];
      if (seen_rv[ID_V]) rv_seen = 1'b1;
    end
    check("rst_regrant", 32'(got), 1);
    check("rst_no_rvalid", 32'(rv_seen), 0);
    wait_idle();

    // Random traffic with occasional reset pulses.
    mode_f = 1; mode_v = 1; mode_d = 1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 249) != 0);
      tick();
    end
    reset = 1'b1;
    mode_f = 0; mode_v = 0; mode_d = 0;
    for (int i = 0; i < 100 && (bif.req_flip || bif.req_vali || bif.req_draw); i++) tick();
    check("drain_done", 32'(bif.req_flip || bif.req_vali || bif.req_draw), 0);
    wait_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
